line_position_tracker: RTL and testbench
========================================

LINE_POSITION_TRACKER -- requirements
Module: line_position_tracker

Interface
REQ-001 Parameter N_SENSORS, default 8, sensor count along the line array (legal range 2..32).
REQ-002 Parameter FILTER_DEPTH, default 2, consecutive identical valid samples required to accept a new position (legal range 1..15).
REQ-003 Parameter LOST_HOLD, default 16, accepted all-zero samples tolerated before declaring line lost (legal range 1..255).
REQ-004 Derived constant POS_W = clog2(2*N_SENSORS); equals 4 for N_SENSORS=8.
REQ-005 clk  input  1  single block clock; all state advances on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 process  input  N_SENSORS  raw sensor bits, asynchronous to clk; bit i is sensor i.
REQ-008 sample_en  input  1  sample strobe; filter and FSM advance only on edges where it is high.
REQ-009 position  output  POS_W  filtered line position code.
REQ-010 pos_valid  output  1  high while position is trustworthy (TRACK or HOLD).
REQ-011 lost  output  1  high while in LOST state.
REQ-012 last_side  output  1  0 = line last seen in lower half (code <= N_SENSORS), 1 = upper half.
REQ-013 invalid  output  1  one-cycle pulse for a sampled illegal pattern.
REQ-014 err_cnt  output  8  saturating count of illegal samples.

Function
REQ-015 process passes through a two-flop synchroniser clocked every cycle, independent of sample_en.
REQ-016 Decode of synchronised pattern: all zero -> 0; single bit i -> 2i+1; adjacent pair i,i+1 -> 2i+2; anything else illegal.
REQ-017 On a sample with illegal pattern: candidate count cleared to 0, invalid pulses high next cycle, err_cnt increments saturating at 255, position and FSM unchanged.
REQ-018 On a sample with legal code equal to candidate: count increments, saturating at FILTER_DEPTH; otherwise candidate loads code and count loads 1.
REQ-019 Code is accepted on the edge where the next count equals FILTER_DEPTH; acceptance of an already-accepted code has no effect.
REQ-020 Latency: stable new pattern with sample_en held high appears on position exactly FILTER_DEPTH+2 rising edges after the input change.
REQ-021 FSM states IDLE, TRACK, HOLD, LOST; IDLE -> TRACK on accepted nonzero code; IDLE stays IDLE on accepted zero.
REQ-022 TRACK: accepted nonzero code loads position and last_side; accepted zero -> HOLD with hold counter cleared.
REQ-023 HOLD: position frozen at last nonzero code, pos_valid stays high; each sample whose decoded code is 0 increments hold counter; at LOST_HOLD such samples -> LOST.
REQ-024 HOLD or LOST: accepted nonzero code -> TRACK, loads position, clears hold counter, same edge.
REQ-025 LOST: pos_valid low, lost high, position and last_side retain final values for recovery steering.
REQ-026 A nonzero code and hold-counter expiry on the same sample: nonzero acceptance wins (TRACK).
REQ-027 sample_en low: filter, FSM, counters, err_cnt hold; invalid not pulsed.

Reset
REQ-028 reset_n low asynchronously clears synchroniser, candidate, counts, err_cnt; FSM to IDLE; position=0, pos_valid=0, lost=0, last_side=0, invalid=0.
REQ-029 Reset assertion mid-HOLD or mid-filter discards all progress; after release, behaviour identical to power-up.

Structure
REQ-030 Package line_sense_pkg holds FSM state enum, POS_W derivation function and err_cnt width constant.
REQ-031 Pattern decode (REQ-016) is a combinational sub-module line_position_decode, outputs code and illegal flag.

Verification (N_SENSORS=8, FILTER_DEPTH=2, LOST_HOLD=4, sample_en high unless noted)
REQ-032 Reset release, process=8'h10 held -> position=9, pos_valid=1 at edge 4; last_side=1.
REQ-033 Walk 8'h01,03,02,...,C0,80, each held 6 cycles -> position steps 1..15; 8'h00 before first line keeps state IDLE, pos_valid=0.
REQ-034 Position 5 tracked, then 8'h00 held -> position stays 5, pos_valid=1 through HOLD; after 4 zero samples lost=1, pos_valid=0, position=5; then 8'h04 -> TRACK, position=5, lost=0.
REQ-035 Single-cycle glitch 8'h08 during stable 8'h02 -> position stays 3; pattern 8'h05 -> invalid pulse, err_cnt+1, position unchanged; 300 illegal samples -> err_cnt=255.
REQ-036 sample_en low for 10 cycles while process changes -> outputs frozen; reset_n pulsed low mid-HOLD -> all outputs zero immediately, state IDLE.

Source files
------------

// File: rtl/line_sense_pkg.sv
// Shared types and sizing helpers for the line position tracker.
package line_sense_pkg;

   // Width of the saturating illegal-sample counter.
   localparam int unsigned ERR_CNT_W = 8;

   // Width of the LOST_HOLD countdown (LOST_HOLD is at most 255).
   localparam int unsigned HOLD_CNT_W = 8;

   // Tracker FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_HOLD  = 2'd2,
      ST_LOST  = 2'd3
   } lt_state_e;

   // Position code width: codes run 0..2*N_SENSORS-1.
   function automatic int unsigned pos_width(input int unsigned n_sensors);
      return $clog2(2 * n_sensors);
   endfunction

endpackage

// File: rtl/line_position_decode.sv
// Combinational decode of a synchronised sensor pattern into a position code.
// Zero -> 0, single bit i -> 2i+1, adjacent pair i,i+1 -> 2i+2, else illegal.
module line_position_decode
   import line_sense_pkg::*;
#(
   parameter int unsigned N_SENSORS = 8,
   parameter int unsigned POS_W     = pos_width(N_SENSORS)
)(
   input  logic [N_SENSORS-1:0] pattern,
   output logic [POS_W-1:0]     code_c,
   output logic                 illegal_c
);

   localparam int unsigned CNT_W = $clog2(N_SENSORS + 1);

   logic [CNT_W-1:0] ones;
   logic             pair_hit;

   // Number of active sensors.
   always_comb begin
      ones = '0;
      for (int i = 0; i < N_SENSORS; i++) begin
         ones = ones + CNT_W'(pattern[i]);
      end
   end

   // Code lookup for single-bit and adjacent-pair patterns; anything else is illegal.
   always_comb begin
      code_c    = '0;
      pair_hit  = 1'b0;
      illegal_c = 1'b0;
      for (int i = 0; i < N_SENSORS; i++) begin
         if ((ones == CNT_W'(1)) && pattern[i]) begin
            code_c = POS_W'(2 * i + 1);
         end
      end
      for (int i = 0; i < N_SENSORS - 1; i++) begin
         if ((ones == CNT_W'(2)) && pattern[i] && pattern[i+1]) begin
            code_c   = POS_W'(2 * i + 2);
            pair_hit = 1'b1;
         end
      end
      illegal_c = (ones > CNT_W'(2)) || ((ones == CNT_W'(2)) && !pair_hit);
   end

endmodule

// File: rtl/line_position_tracker.sv
// Line-following position tracker: synchronises raw sensor bits, decodes them
// into a position code, debounces with a consecutive-sample filter and runs a
// TRACK/HOLD/LOST state machine so steering keeps a sane target when the line
// briefly disappears.
module line_position_tracker
   import line_sense_pkg::*;
#(
   parameter  int unsigned N_SENSORS    = 8,
   parameter  int unsigned FILTER_DEPTH = 2,
   parameter  int unsigned LOST_HOLD    = 16,
   localparam int unsigned POS_W        = pos_width(N_SENSORS)
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_SENSORS-1:0] process,
   input  logic                 sample_en,
   output logic [POS_W-1:0]     position,
   output logic                 pos_valid,
   output logic                 lost,
   output logic                 last_side,
   output logic                 invalid,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int unsigned FCNT_W = $clog2(FILTER_DEPTH + 1);

   localparam logic [FCNT_W-1:0]     FILL      = FCNT_W'(FILTER_DEPTH);
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(LOST_HOLD - 1);
   localparam logic [ERR_CNT_W-1:0]  ERR_MAX   = '1;

   logic [N_SENSORS-1:0]  sync_meta;
   logic [N_SENSORS-1:0]  sync_q;

   logic [POS_W-1:0]      code_c;
   logic                  illegal_c;
   logic                  nonzero_c;
   logic                  upper_c;

   logic [POS_W-1:0]      cand_q;
   logic [POS_W-1:0]      cand_d;
   logic [FCNT_W-1:0]     cnt_q;
   logic [FCNT_W-1:0]     cnt_d;
   logic                  accept_c;

   lt_state_e             state_q;
   lt_state_e             state_d;
   logic [HOLD_CNT_W-1:0] hold_q;
   logic [HOLD_CNT_W-1:0] hold_d;
   logic [POS_W-1:0]      position_d;
   logic                  last_side_d;
   logic                  pos_valid_d;
   logic                  lost_d;

   // Two-flop synchroniser for the asynchronous sensor inputs, clocked every cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= process;
         sync_q    <= sync_meta;
      end
   end

   line_position_decode #(
      .N_SENSORS (N_SENSORS),
      .POS_W     (POS_W)
   ) u_decode (
      .pattern   (sync_q),
      .code_c    (code_c),
      .illegal_c (illegal_c)
   );

   assign nonzero_c = |code_c;
   assign upper_c   = (code_c > POS_W'(N_SENSORS));

   // Run-length filter: a legal code is accepted once seen FILTER_DEPTH times in a row.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (illegal_c) begin
         cnt_d = '0;
      end else if (code_c == cand_q) begin
         cnt_d = (cnt_q == FILL) ? cnt_q : cnt_q + FCNT_W'(1);
      end else begin
         cand_d = code_c;
         cnt_d  = FCNT_W'(1);
      end
   end

   assign accept_c = sample_en && !illegal_c && (cnt_d == FILL);

   // Filter candidate and run length advance only on sample strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cand_q <= '0;
         cnt_q  <= '0;
      end else if (sample_en) begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
      end
   end

   // Next state and next registered outputs; a new nonzero line always wins.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      position_d  = position;
      last_side_d = last_side;
      pos_valid_d = 1'b0;
      lost_d      = 1'b0;

      if (sample_en && !illegal_c) begin
         if (accept_c && nonzero_c) begin
            state_d     = ST_TRACK;
            position_d  = code_c;
            last_side_d = upper_c;
            hold_d      = '0;
         end else if (!nonzero_c) begin
            if ((state_q == ST_TRACK) && accept_c) begin
               state_d = ST_HOLD;
               hold_d  = '0;
            end else if (state_q == ST_HOLD) begin
               if (hold_q == HOLD_LAST) begin
                  state_d = ST_LOST;
               end else begin
                  hold_d = hold_q + HOLD_CNT_W'(1);
               end
            end
         end
      end

      pos_valid_d = (state_d == ST_TRACK) || (state_d == ST_HOLD);
      lost_d      = (state_d == ST_LOST);
   end

   // FSM state, hold counter and tracking outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         hold_q    <= '0;
         position  <= '0;
         last_side <= 1'b0;
         pos_valid <= 1'b0;
         lost      <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         position  <= position_d;
         last_side <= last_side_d;
         pos_valid <= pos_valid_d;
         lost      <= lost_d;
      end
   end

   // Illegal-sample pulse and saturating error count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         invalid <= 1'b0;
         err_cnt <= '0;
      end else begin
         invalid <= sample_en && illegal_c;
         if (sample_en && illegal_c && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_line_position_tracker.sv
// Randomised self-checking bench for line_position_tracker against a
// behavioural model (pipeline of raw samples, bit-count decode, history queue).
module tb_line_position_tracker;

   localparam int NS = 8;
   localparam int FD = 2;
   localparam int LH = 4;

   localparam int MD_IDLE = 0;
   localparam int MD_ON   = 1;
   localparam int MD_MISS = 2;
   localparam int MD_GONE = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NS-1:0] process;
   logic          sample_en;
   logic [3:0]    position;
   logic          pos_valid;
   logic          lost;
   logic          last_side;
   logic          invalid;
   logic [7:0]    err_cnt;

   int vecs = 0;
   int errs = 0;

   // model state
   logic [NS-1:0] m_s1, m_s2;
   int            hist[$];
   int            m_mode, m_zeros, m_pos, m_err;
   bit            m_side, m_inv;

   line_position_tracker #(
      .N_SENSORS    (NS),
      .FILTER_DEPTH (FD),
      .LOST_HOLD    (LH)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .process   (process),
      .sample_en (sample_en),
      .position  (position),
      .pos_valid (pos_valid),
      .lost      (lost),
      .last_side (last_side),
      .invalid   (invalid),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   wire [15:0] dut_vec = {position, pos_valid, lost, last_side, invalid, err_cnt};

   function automatic logic [15:0] exp_vec();
      logic v, l;
      v = (m_mode == MD_ON) || (m_mode == MD_MISS);
      l = (m_mode == MD_GONE);
      return {4'(m_pos), v, l, m_side, m_inv, 8'(m_err)};
   endfunction

   function automatic void mdecode(input logic [NS-1:0] p, output bit legal, output int code);
      int n, lo;
      n = 0; lo = -1;
      for (int i = 0; i < NS; i++) if (p[i]) begin n++; if (lo < 0) lo = i; end
      legal = 1'b1; code = 0;
      if (n == 1) code = 2 * lo + 1;
      else if (n == 2) begin
         if (lo < NS - 1 && p[lo+1]) code = 2 * lo + 2;
         else legal = 1'b0;
      end else if (n > 2) legal = 1'b0;
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; hist.delete();
      m_mode = MD_IDLE; m_zeros = 0; m_pos = 0; m_err = 0;
      m_side = 1'b0; m_inv = 1'b0;
   endtask

   // Advance the model by one rising edge using the inputs present before it.
   task automatic model_step();
      bit legal, acc;
      int code;
      if (!reset_n) begin model_reset(); return; end
      m_inv = 1'b0;
      if (sample_en) begin
         mdecode(m_s2, legal, code);
         if (!legal) begin
            hist.delete();
            m_inv = 1'b1;
            if (m_err < 255) m_err++;
         end else begin
            hist.push_back(code);
            if (hist.size() > FD) void'(hist.pop_front());
            acc = (hist.size() == FD);
            foreach (hist[k]) if (hist[k] != code) acc = 1'b0;
            if (acc && code != 0) begin
               m_mode = MD_ON; m_pos = code; m_side = (code > NS); m_zeros = 0;
            end else if (code == 0) begin
               if (acc && m_mode == MD_ON) begin
                  m_mode = MD_MISS; m_zeros = 0;
               end else if (m_mode == MD_MISS) begin
                  m_zeros++;
                  if (m_zeros >= LH) m_mode = MD_GONE;
               end
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = process;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      model_reset();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; process = '0; sample_en = 1'b1;
      model_reset();
      for (int c = 0; c < 3; c++) begin
         tick();
         vecs++;
         if (dut_vec !== 16'h0) begin
            errs++;
            $display("FAIL reset_state cyc=%0d got=%h exp=%h", c, dut_vec, 16'h0);
         end
      end
   endtask

   task automatic test_first_acquire();
      reset_n = 1'b0; model_reset();
      process = 8'h10;
      tick();
      reset_n = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick();
         vecs++;
         if (dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL acquire_model edge=%0d got=%h exp=%h", e, dut_vec, exp_vec());
         end
         if (e == 3) begin
            vecs++;
            if ({position, pos_valid} !== {4'd0, 1'b0}) begin
               errs++;
               $display("FAIL acquire_early edge=3 got pos=%0d v=%0b exp pos=0 v=0", position, pos_valid);
            end
         end
         if (e == 4) begin
            vecs++;
            if ({position, pos_valid, last_side} !== {4'd9, 1'b1, 1'b1}) begin
               errs++;
               $display("FAIL acquire_edge4 got pos=%0d v=%0b side=%0b exp pos=9 v=1 side=1",
                        position, pos_valid, last_side);
            end
         end
      end
   endtask

   task automatic test_walk();
      logic [7:0] pats [15];
      pats = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h04, 8'h0C, 8'h08, 8'h18,
               8'h10, 8'h30, 8'h20, 8'h60, 8'h40, 8'hC0, 8'h80};
      process = 8'h00;
      pulse_reset();
      for (int c = 0; c < 8; c++) begin
         tick();
         vecs++;
         if ({pos_valid, lost, position} !== {1'b0, 1'b0, 4'd0} || dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL walk_idle cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
      end
      for (int k = 0; k < 15; k++) begin
         process = pats[k];
         for (int c = 0; c < 6; c++) begin
            tick();
            vecs++;
            if (dut_vec !== exp_vec()) begin
               errs++;
               $display("FAIL walk_model pat=%h cyc=%0d got=%h exp=%h", pats[k], c, dut_vec, exp_vec());
            end
         end
         vecs++;
         if ({position, pos_valid} !== {4'(k + 1), 1'b1}) begin
            errs++;
            $display("FAIL walk_step pat=%h got pos=%0d v=%0b exp pos=%0d v=1", pats[k], position, pos_valid, k + 1);
         end
      end
   endtask

   task automatic test_hold_lost();
      process = 8'h04;
      pulse_reset();
      for (int c = 0; c < 6; c++) tick();
      vecs++;
      if ({position, pos_valid} !== {4'd5, 1'b1}) begin
         errs++;
         $display("FAIL hold_setup got pos=%0d v=%0b exp pos=5 v=1", position, pos_valid);
      end
      process = 8'h00;
      for (int c = 1; c <= 12; c++) begin
         tick();
         vecs++;
         if (dut_vec !== exp_vec() || position !== 4'd5) begin
            errs++;
            $display("FAIL hold_model cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
         if (c == 7 || c == 8) begin
            vecs++;
            if ({pos_valid, lost} !== ((c == 7) ? 2'b10 : 2'b01)) begin
               errs++;
               $display("FAIL hold_expiry cyc=%0d got v=%0b l=%0b exp v=%0b l=%0b",
                        c, pos_valid, lost, c == 7, c == 8);
            end
         end
      end
      process = 8'h04;
      for (int c = 0; c < 6; c++) begin
         tick();
         vecs++;
         if (dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL recover_model cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
      end
      vecs++;
      if ({position, pos_valid, lost} !== {4'd5, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL recover got pos=%0d v=%0b l=%0b exp pos=5 v=1 l=0", position, pos_valid, lost);
      end
   endtask

   task automatic test_glitch();
      int pulses;
      process = 8'h02;
      pulse_reset();
      for (int c = 0; c < 6; c++) tick();
      process = 8'h08;
      tick();
      process = 8'h02;
      for (int c = 0; c < 8; c++) begin
         tick();
         vecs++;
         if (position !== 4'd3 || dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL glitch cyc=%0d got=%h exp pos=3 vec=%h", c, dut_vec, exp_vec());
         end
      end
      process = 8'h05;
      tick();
      process = 8'h02;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (invalid) pulses++;
         vecs++;
         if (dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL illegal_model cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
      end
      vecs++;
      if (pulses != 1 || err_cnt !== 8'd1 || position !== 4'd3) begin
         errs++;
         $display("FAIL illegal_one got pulses=%0d err=%0d pos=%0d exp pulses=1 err=1 pos=3",
                  pulses, err_cnt, position);
      end
      process = 8'h05;
      for (int c = 0; c < 305; c++) begin
         tick();
         vecs++;
         if (dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL err_sat_model cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
      end
      vecs++;
      if (err_cnt !== 8'd255 || position !== 4'd3) begin
         errs++;
         $display("FAIL err_sat got err=%0d pos=%0d exp err=255 pos=3", err_cnt, position);
      end
   endtask

   task automatic test_sample_en();
      process = 8'h40;
      pulse_reset();
      for (int c = 0; c < 6; c++) tick();
      sample_en = 1'b0;
      for (int c = 0; c < 10; c++) begin
         process = 8'($urandom);
         tick();
         vecs++;
         if (dut_vec !== {4'd13, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0} || dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL sample_en_freeze cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
      end
      sample_en = 1'b1;
      process = 8'h02;
      for (int c = 0; c < 6; c++) begin
         tick();
         vecs++;
         if (dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL sample_en_resume cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      process = 8'h20;
      pulse_reset();
      for (int c = 0; c < 6; c++) tick();
      process = 8'h00;
      for (int c = 0; c < 5; c++) tick();
      vecs++;
      if ({position, pos_valid, lost} !== {4'd11, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL mid_hold_setup got pos=%0d v=%0b l=%0b exp pos=11 v=1 l=0", position, pos_valid, lost);
      end
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      vecs++;
      if (dut_vec !== 16'h0) begin
         errs++;
         $display("FAIL async_reset got=%h exp=%h", dut_vec, 16'h0);
      end
      process = 8'h10;
      tick();
      reset_n = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick();
         vecs++;
         if (dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL post_reset edge=%0d got=%h exp=%h", e, dut_vec, exp_vec());
         end
      end
      vecs++;
      if ({position, pos_valid, last_side} !== {4'd9, 1'b1, 1'b1}) begin
         errs++;
         $display("FAIL post_reset_acquire got pos=%0d v=%0b side=%0b exp pos=9 v=1 side=1",
                  position, pos_valid, last_side);
      end
   endtask

   task automatic test_random();
      int hold_left, r, b;
      process = 8'h00;
      pulse_reset();
      hold_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold_left == 0) begin
            r = $urandom_range(0, 9);
            b = $urandom_range(0, NS - 1);
            if (r == 0 || r == 9)  process = 8'h00;
            else if (r <= 4)       process = 8'(1 << b);
            else if (r <= 7)       process = 8'(3 << ((b == NS - 1) ? NS - 2 : b));
            else                   process = 8'($urandom);
            hold_left = $urandom_range(1, 8);
         end
         hold_left--;
         sample_en = ($urandom_range(0, 9) != 0);
         tick();
         vecs++;
         if (dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL random cyc=%0d in=%h got=%h exp=%h", c, process, dut_vec, exp_vec());
         end
      end
      sample_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_first_acquire();
      test_walk();
      test_hold_lost();
      test_glitch();
      test_sample_en();
      test_reset_mid_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
